deser8: RTL
===========

// Module: deser8
// PURPOSE
//  1:8 serial-to-parallel deserializer. The inverse of the 8:1 select mux.
//  Collects recovered serial bits from the CDR data path and assembles 8-bit words.
//  Hands each word to downstream logic over a valid/ready handshake.
//  Sits between the phase-selected bit output of the CDR and the word-level consumer.
// PARAMETERS
//  SYNC_WORD  8'hAA  alignment pattern; used only when DESER8_ALIGN_EN is defined
// PORTS
//  clk         in   1  system clock; all logic on the rising edge
//  rst         in   1  reset, synchronous, active-high
//  din         in   1  serial data bit
//  din_valid   in   1  din is sampled on this cycle
//  bit_idx     out  3  word bit position the next valid din is written to
//  word_out    out  8  assembled word; bit k = k-th bit received (LSB first)
//  word_valid  out  1  word_out holds an unconsumed word
//  word_ready  in   1  consumer accepts word_out when word_valid is also high
//  overrun     out  1  sticky flag: a completed word was dropped
//  aligned     out  1  word boundary established (tied 1 without DESER8_ALIGN_EN)
// BEHAVIOUR
//  - Reset values: bit_idx=0, word_out=0, word_valid=0, overrun=0, shift reg=0.
//    aligned resets to 0 with DESER8_ALIGN_EN, and to 1 without it.
//  - Reset mid-word discards all partial bits; the next valid bit is bit 0.
//  - Cycles with din_valid=0 change no state. Gaps between bits are allowed.
//  - Bit capture, on din_valid and aligned: shift[bit_idx] <= din, then bit_idx increments.
//    At bit_idx=7 the increment wraps bit_idx to 0 and completes a word.
//  - Latency: word_valid rises on the cycle after the 8th bit is sampled.
//    word_out contains all 8 bits at that point.
//  - Handshake: the transfer occurs on a cycle with word_valid & word_ready.
//    After a transfer with no new word completing, word_valid=0 on the next cycle.
//    word_out is stable while word_valid=1 and word_ready=0.
//  - Completion with word_valid=0: load word_out and set word_valid.
//  - Completion on the same cycle as a transfer: load the new word; word_valid stays 1.
//  - Completion with word_valid=1 and word_ready=0:
//    the new word is dropped, word_out keeps the old word, overrun <= 1.
//    overrun is cleared only by rst.
//  - Assembly continues regardless of backpressure. din is never stalled.
// CONFIGURATION
//  - Macro DESER8_ALIGN_EN adds a 2-state FSM: HUNT and LOCK.
//  - HUNT (reset state, aligned=0):
//    on each valid bit, an 8-bit sliding window shifts in din.
//    Window order: newest bit at bit 7, i.e. LSB-first order.
//    bit_idx is held at 0 and no words are produced.
//  - HUNT -> LOCK: when the window including the current bit equals SYNC_WORD.
//    The sync word itself is not output. aligned=1 from the next cycle.
//    The next valid bit is bit 0.
//  - LOCK: normal capture as described above. There is no return to HUNT except via rst.
//  - Without the macro: no FSM, no window register, aligned=1 constantly.
//    Capture starts at the first valid bit after reset.
// TESTING
//  1. Send 0,1,0,1,0,1,0,1 (one per cycle), word_ready=1
//     -> word_out=8'hAA, word_valid high one cycle after bit 8, bit_idx back to 0.
//  2. Send the same 8 bits with din_valid=0 gaps of 1-3 cycles
//     -> same 8'hAA; bit_idx holds during the gaps.
//  3. word_ready=0; send 8'h3C then 8'hC3
//     -> word_out stays 8'h3C, overrun=1.
//     Then word_ready=1 -> word_valid=0 the next cycle; overrun remains 1.
//  4. word_ready=1; stream 8'h01 and 8'h80 back to back
//     -> two single-cycle word_valid pulses, 8 cycles apart, with no overrun.
//  5. Assert rst after 5 bits, then send 8'hFF
//     -> word_out=8'hFF with no leftover bits; bit_idx=0 after rst.
//  6. With DESER8_ALIGN_EN: send 3 junk bits, then SYNC_WORD, then 8'h5A
//     -> aligned rises after the sync word; only 8'h5A is output.

Source files
------------

// File: rtl/deser8.sv
// 1:8 LSB-first serial-to-parallel deserializer with a valid/ready word output.
// Defining DESER8_ALIGN_EN adds a HUNT/LOCK framing search for SYNC_WORD.
module deser8 #(
    parameter logic [7:0] SYNC_WORD = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    output logic [2:0] bit_idx,
    output logic [7:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       overrun,
    output logic       aligned
);

    logic [7:0] sr;
    logic [7:0] new_word;
    logic       cap;
    logic       done;

    assign cap      = din_valid & aligned;
    assign done     = cap && (bit_idx == 3'd7);
    // The 8th bit is still on din, so merge it in directly.
    assign new_word = {din, sr[6:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            bit_idx    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (cap) begin
                sr[bit_idx] <= din;
                bit_idx     <= bit_idx + 3'd1;
            end
            if (done) begin
                // Accept the new word if the slot is empty or being drained now.
                if (!word_valid || word_ready) begin
                    word_out   <= new_word;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef DESER8_ALIGN_EN
    typedef enum logic {HUNT, LOCK} state_t;

    state_t     state, state_nxt;
    logic [7:0] window;
    logic [7:0] window_nxt;

    // Newest bit enters at the top so the window reads in LSB-first order.
    assign window_nxt = {din, window[7:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HUNT;
            window <= '0;
        end else begin
            state <= state_nxt;
            if (din_valid && state == HUNT) window <= window_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == HUNT && din_valid && window_nxt == SYNC_WORD) state_nxt = LOCK;
    end

    assign aligned = (state == LOCK);
`else
    assign aligned = 1'b1;
`endif

endmodule
